// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared encodings for the memory stage
// Op codes, register index width and the memory-wait FSM state type.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    OP_BR  = 2'b00,
    OP_ADD = 2'b01,
    OP_LDW = 2'b10,
    OP_STW = 2'b11
  } op_e;

  localparam int DR_W = 3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_e;

  // LDW and STW are the only ops with bit 1 set.
  function automatic logic is_mem_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory request/acknowledge bus
// The pipeline stage is the master; the data memory is the slave.
interface mem_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-2:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_stage_wait_timer.sv
// rtl/mem_stage_wait_timer.sv - acknowledge wait counter
// Loads 1 on start, counts while waiting, flags expiry at ACK_TIMEOUT.
module mem_wait_timer #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic clear_i,
  input  logic inc_i,
  output logic expire_o
);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)      cnt_d = '0;
    else if (start_i) cnt_d = CNT_W'(1);
    else if (inc_i)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == CNT_W'(ACK_TIMEOUT));
endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage with stalling data-memory access
// Issues LDW/STW to data memory, stalls EX while waiting, registers the WB bundle.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        op_i,
  input  logic [DR_W-1:0]   dr_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic [DATA_W-1:0] memdata_i,
  output logic              stall_o,
  output logic [1:0]        op_mem_return_o,
  output logic [DR_W-1:0]   dr_mem_return_o,
  mem_stage_if.master       dmem,
  output logic              wb_valid_o,
  output logic [1:0]        op_to_wb_o,
  output logic [DR_W-1:0]   dr_to_wb_o,
  output logic [DATA_W-1:0] result_to_wb_o,
  output logic              err_misalign_o,
  output logic              err_timeout_o
);
  mem_state_e        state_q;
  logic [1:0]        hold_op_q;
  logic [DR_W-1:0]   hold_dr_q;
  logic [DATA_W-1:0] hold_result_q;
  logic [DATA_W-1:0] hold_wdata_q;

  logic              in_wait, idle_mem, expire, retire;
  logic [1:0]        cur_op;
  logic [DR_W-1:0]   cur_dr;
  logic [DATA_W-1:0] cur_result, cur_wdata;

  assign in_wait    = (state_q == S_WAIT);
  assign idle_mem   = ~in_wait & is_mem_op(op_i) & ~result_i[0];
  assign cur_op     = in_wait ? hold_op_q     : op_i;
  assign cur_dr     = in_wait ? hold_dr_q     : dr_i;
  assign cur_result = in_wait ? hold_result_q : result_i;
  assign cur_wdata  = in_wait ? hold_wdata_q  : memdata_i;

  // Gating with rst_n makes an asserted reset drop the request at once.
  assign dmem.req   = rst_n & (in_wait | idle_mem);
  assign dmem.we    = cur_op[0];
  assign dmem.addr  = cur_result[ADDR_W-1:1];
  assign dmem.wdata = cur_wdata;

  // The timeout cycle releases EX even though no ack arrived.
  assign stall_o         = dmem.req & ~dmem.ack & ~(in_wait & expire);
  assign op_mem_return_o = cur_op;
  assign dr_mem_return_o = cur_dr;

  assign retire = in_wait ? dmem.ack : (~is_mem_op(op_i) | (idle_mem & dmem.ack));

  mem_wait_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (idle_mem & ~dmem.ack),
    .clear_i  (in_wait & (dmem.ack | expire)),
    .inc_i    (in_wait & ~dmem.ack),
    .expire_o (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      hold_op_q      <= '0;
      hold_dr_q      <= '0;
      hold_result_q  <= '0;
      hold_wdata_q   <= '0;
      wb_valid_o     <= 1'b0;
      op_to_wb_o     <= '0;
      dr_to_wb_o     <= '0;
      result_to_wb_o <= '0;
      err_misalign_o <= 1'b0;
      err_timeout_o  <= 1'b0;
    end else begin
      wb_valid_o     <= retire;
      err_misalign_o <= 1'b0;
      if (retire) begin
        op_to_wb_o     <= cur_op;
        dr_to_wb_o     <= cur_dr;
        result_to_wb_o <= (cur_op == OP_LDW) ? dmem.rdata : cur_result;
      end
      if (state_q == S_IDLE) begin
        err_misalign_o <= is_mem_op(op_i) & result_i[0];
        if (idle_mem && !dmem.ack) begin
          state_q       <= S_WAIT;
          hold_op_q     <= op_i;
          hold_dr_q     <= dr_i;
          hold_result_q <= result_i;
          hold_wdata_q  <= memdata_i;
        end
      end else if (dmem.ack) begin
        state_q <= S_IDLE;
      end else if (expire) begin
        state_q       <= S_IDLE;
        err_timeout_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for the memory stage
// Stimulus pushes expected retirements; monitors check bus, stall and WB outputs.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  op_i;
  logic [2:0]  dr_i;
  logic [15:0] result_i, memdata_i;
  logic        stall_o, wb_valid, err_mis, err_to;
  logic [1:0]  op_ret, op_wb;
  logic [2:0]  dr_ret, dr_wb;
  logic [15:0] res_wb;

  mem_stage_if #(.DATA_W(16), .ADDR_W(16)) dmem_if ();

  mem_stage #(.DATA_W(16), .ADDR_W(16), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .op_i(op_i), .dr_i(dr_i), .result_i(result_i),
    .memdata_i(memdata_i), .stall_o(stall_o), .op_mem_return_o(op_ret),
    .dr_mem_return_o(dr_ret), .dmem(dmem_if), .wb_valid_o(wb_valid),
    .op_to_wb_o(op_wb), .dr_to_wb_o(dr_wb), .result_to_wb_o(res_wb),
    .err_misalign_o(err_mis), .err_timeout_o(err_to)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [1:0]  op;
    logic [2:0]  dr;
    logic [15:0] res;
    logic        mis;
    logic        to;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic        mon_en = 1'b0, active = 1'b0, exp_stall = 1'b0, exp_req = 1'b0;
  logic        retiring = 1'b0, exp_to_sticky = 1'b0, exp_we = 1'b0;
  logic [14:0] exp_addr = '0;
  logic [15:0] exp_wdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One instruction held on the EX outputs until the stage releases it.
  // d = cycle index (0 = first cycle) at which memory acks; d > 15 means never.
  task automatic issue(input logic [1:0] op, input logic [2:0] dr, input logic [15:0] res,
                       input logic [15:0] md, input int d, input logic [15:0] rd);
    exp_t e;
    logic mem;
    int   n;
    mem     = op[1] && !res[0];
    n       = !mem ? 0 : (d > 15 ? 15 : d);
    e.valid = !(op[1] && res[0]) && !(mem && d > 15);
    e.op    = op;
    e.dr    = dr;
    e.res   = (op == 2'b10) ? rd : res;
    e.mis   = op[1] && res[0];
    e.to    = mem && (d > 15);
    exp_q.push_back(e);
    op_i = op; dr_i = dr; result_i = res; memdata_i = md;
    exp_addr = res[15:1]; exp_we = op[0]; exp_wdata = md;
    active = 1'b1;
    for (int k = 0; k <= n; k++) begin
      exp_stall     = (k < n);
      exp_req       = mem;
      dmem_if.ack   = mem ? (k == d) : 1'($urandom_range(0, 1));
      dmem_if.rdata = (mem && k == d) ? rd : 16'($urandom);
      @(posedge clk); #2;
    end
  endtask

  initial begin : bus_monitor
    forever begin
      @(negedge clk);
      retiring = 1'b0;
      if (mon_en && active) begin
        chk("stall", 32'(stall_o), 32'(exp_stall));
        chk("req", 32'(dmem_if.req), 32'(exp_req));
        chk("op_return", 32'(op_ret), 32'(op_i));
        chk("dr_return", 32'(dr_ret), 32'(dr_i));
        if (exp_req) begin
          chk("addr", 32'(dmem_if.addr), 32'(exp_addr));
          chk("we", 32'(dmem_if.we), 32'(exp_we));
          chk("wdata", 32'(dmem_if.wdata), 32'(exp_wdata));
        end
        retiring = !exp_stall;
      end
    end
  end

  initial begin : wb_monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (mon_en) begin
        if (retiring) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: retirement with empty queue at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("wb_valid", 32'(wb_valid), 32'(e.valid));
            if (e.valid) begin
              chk("op_to_wb", 32'(op_wb), 32'(e.op));
              chk("dr_to_wb", 32'(dr_wb), 32'(e.dr));
              chk("result_to_wb", 32'(res_wb), 32'(e.res));
            end
            chk("err_misalign", 32'(err_mis), 32'(e.mis));
            exp_to_sticky = exp_to_sticky | e.to;
          end
        end else begin
          chk("wb_valid_stalled", 32'(wb_valid), 32'd0);
          chk("err_misalign_idle", 32'(err_mis), 32'd0);
        end
        chk("err_timeout", 32'(err_to), 32'(exp_to_sticky));
      end
    end
  end

  initial begin : stimulus
    logic [1:0]  op;
    logic [15:0] res;
    int          d;
    rst_n = 1'b0; op_i = 2'b00; dr_i = '0; result_i = '0; memdata_i = '0;
    dmem_if.ack = 1'b0; dmem_if.rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_op_wb", 32'(op_wb), 32'd0);
    chk("rst_dr_wb", 32'(dr_wb), 32'd0);
    chk("rst_res_wb", 32'(res_wb), 32'd0);
    chk("rst_errs", {30'd0, err_mis, err_to}, 32'd0);
    chk("rst_req", 32'(dmem_if.req), 32'd0);
    @(posedge clk); #2;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    issue(2'b01, 3'd3, 16'h0042, 16'h0000, 0, 16'h0000);
    issue(2'b10, 3'd5, 16'h0010, 16'h0000, 0, 16'hBEEF);
    issue(2'b11, 3'd1, 16'h0020, 16'h1234, 3, 16'h0000);
    issue(2'b10, 3'd2, 16'h0030, 16'h0000, 16, 16'h0000);
    issue(2'b10, 3'd4, 16'h0011, 16'h0000, 0, 16'h0000);
    issue(2'b10, 3'd6, 16'h0100, 16'h0000, 15, 16'h5A5A);
    issue(2'b00, 3'd7, 16'hFFFF, 16'h0000, 0, 16'h0000);

    for (int i = 0; i < 150; i++) begin
      op  = 2'($urandom_range(0, 3));
      res = 16'($urandom);
      res[0] = op[1] && ($urandom_range(0, 5) == 0);
      d   = ($urandom_range(0, 9) == 0) ? 16 : int'($urandom_range(0, 6));
      issue(op, 3'($urandom), res, 16'($urandom), d, 16'($urandom));
    end
    active = 1'b0;
    mon_en = 1'b0;

    // Asynchronous reset while a load is waiting.
    op_i = 2'b10; dr_i = 3'd1; result_i = 16'h0040; dmem_if.ack = 1'b0;
    repeat (3) begin @(posedge clk); #2; end
    chk("wait_req", 32'(dmem_if.req), 32'd1);
    chk("wait_stall", 32'(stall_o), 32'd1);
    chk("timeout_sticky", 32'(err_to), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(dmem_if.req), 32'd0);
    chk("arst_stall", 32'(stall_o), 32'd0);
    chk("arst_err_timeout", 32'(err_to), 32'd0);
    chk("arst_wb", {wb_valid, op_wb, dr_wb, res_wb}, 32'd0);
    #20;
    rst_n = 1'b1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end
endmodule
